// File: rtl/aes_round_controller.sv
// Sequencing controller for an iterative AES-128 encryptor: holds the expanded key and the
// running state, and steps an external combinational round datapath through rounds 1..10.
module aes_round_controller (
    input  logic           clk,
    input  logic           reset,
    input  logic           key_load,
    input  logic [1407:0]  expanded_key,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [127:0]   in_block,
    output logic [127:0]   dp_state,
    output logic [127:0]   dp_round_key,
    output logic           dp_last,
    input  logic [127:0]   dp_result,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [127:0]   out_block,
    output logic           busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t          state;
    logic [3:0]      round_cnt;
    logic            key_valid;
    logic [1407:0]   key_reg;
    logic [127:0]    state_reg;
    logic            accept;
    logic            key_wr;

    // A key load in the same cycle as an offered block wins; the block waits a cycle.
    assign in_ready  = (state == IDLE) & key_valid & ~key_load;
    assign accept    = in_valid & in_ready;
    assign key_wr    = key_load & ((state == IDLE) | (state == DONE));
    assign dp_state  = state_reg;
    assign out_block = state_reg;

    always_comb begin
        dp_round_key = '0;
        if (state == ROUND) begin
            for (int r = 1; r <= 10; r++) begin
                if (round_cnt == r[3:0]) begin
                    dp_round_key = key_reg[128*r +: 128];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            round_cnt <= 4'd0;
            key_valid <= 1'b0;
            key_reg   <= '0;
            state_reg <= '0;
            dp_last   <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            if (key_wr) begin
                key_reg   <= expanded_key;
                key_valid <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (accept) begin
                        state_reg <= in_block ^ key_reg[127:0];
                        round_cnt <= 4'd1;
                        state     <= ROUND;
                        busy      <= 1'b1;
                    end
                end
                ROUND: begin
                    state_reg <= dp_result;
                    if (round_cnt == 4'd10) begin
                        round_cnt <= 4'd0;
                        dp_last   <= 1'b0;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        round_cnt <= round_cnt + 4'd1;
                        dp_last   <= (round_cnt == 4'd9);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    round_cnt <= 4'd0;
                    dp_last   <= 1'b0;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aes_round_controller.sv
// Bench for aes_round_controller: supplies a behavioural AES round datapath and key expansion,
// and checks ciphertexts against a scoreboard of software-encrypted blocks.
module tb_aes_round_controller;

    logic           clk = 1'b0;
    logic           reset;
    logic           key_load;
    logic [1407:0]  expanded_key;
    logic           in_valid;
    logic           in_ready;
    logic [127:0]   in_block;
    logic [127:0]   dp_state;
    logic [127:0]   dp_round_key;
    logic           dp_last;
    logic [127:0]   dp_result;
    logic           out_valid;
    logic           out_ready;
    logic [127:0]   out_block;
    logic           busy;

    int             n_checks = 0;
    int             n_fail   = 0;
    logic [127:0]   exp_q[$];
    logic [1407:0]  mdl_key;

    aes_round_controller dut (
        .clk          (clk),
        .reset        (reset),
        .key_load     (key_load),
        .expanded_key (expanded_key),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_block     (in_block),
        .dp_state     (dp_state),
        .dp_round_key (dp_round_key),
        .dp_last      (dp_last),
        .dp_result    (dp_result),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_block    (out_block),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        logic [7:0] y = b;
        for (int k = 0; k < 8; k++) begin
            if (y[0]) p = p ^ x;
            x = xtime(x);
            y = {1'b0, y[7:1]};
        end
        return p;
    endfunction

    // Inverse as a^254 = product of a^(2^k), k=1..7, then the affine transform.
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] sq = a;
        logic [7:0] p  = 8'h01;
        for (int k = 1; k < 8; k++) begin
            sq = gmul(sq, sq);
            p  = gmul(p, sq);
        end
        return p ^ {p[6:0], p[7]} ^ {p[5:0], p[7:6]} ^ {p[4:0], p[7:5]} ^ {p[3:0], p[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] rk,
                                               input logic last);
        logic [7:0]   b [16];
        logic [7:0]   t [16];
        logic [7:0]   m [16];
        logic [127:0] o;
        for (int i = 0; i < 16; i++) b[i] = sbox(s[127-8*i -: 8]);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                t[r+4*c] = b[r+4*((c+r)%4)];
        for (int c = 0; c < 4; c++) begin
            if (last) begin
                for (int r = 0; r < 4; r++) m[r+4*c] = t[r+4*c];
            end else begin
                m[4*c]   = gmul(t[4*c], 8'h02) ^ gmul(t[4*c+1], 8'h03) ^ t[4*c+2] ^ t[4*c+3];
                m[4*c+1] = t[4*c] ^ gmul(t[4*c+1], 8'h02) ^ gmul(t[4*c+2], 8'h03) ^ t[4*c+3];
                m[4*c+2] = t[4*c] ^ t[4*c+1] ^ gmul(t[4*c+2], 8'h02) ^ gmul(t[4*c+3], 8'h03);
                m[4*c+3] = gmul(t[4*c], 8'h03) ^ t[4*c+1] ^ t[4*c+2] ^ gmul(t[4*c+3], 8'h02);
            end
        end
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = m[i];
        return o ^ rk;
    endfunction

    function automatic logic [1407:0] key_expand(input logic [127:0] key);
        logic [31:0]   w [44];
        logic [31:0]   tmp;
        logic [7:0]    rcon = 8'h01;
        logic [1407:0] ek;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {sbox(tmp[23:16]), sbox(tmp[15:8]), sbox(tmp[7:0]), sbox(tmp[31:24])}
                      ^ {rcon, 24'h000000};
                rcon = xtime(rcon);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int r = 0; r < 11; r++) ek[128*r +: 128] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        return ek;
    endfunction

    function automatic logic [127:0] aes_encrypt(input logic [127:0] pt, input logic [1407:0] ek);
        logic [127:0] s = pt ^ ek[127:0];
        for (int r = 1; r <= 10; r++) s = aes_round(s, ek[128*r +: 128], r == 10);
        return s;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    always_comb dp_result = aes_round(dp_state, dp_round_key, dp_last);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_key(input logic [1407:0] k);
        key_load     = 1'b1;
        expanded_key = k;
        tick();
        key_load = 1'b0;
        mdl_key  = k;
    endtask

    task automatic send_block(input string name, input logic [127:0] b);
        in_valid = 1'b1;
        in_block = b;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s accept: in_ready=%b, required 1", name, in_ready);
        end
        tick();
        in_valid = 1'b0;
        exp_q.push_back(aes_encrypt(b, mdl_key));
    endtask

    // Enters just after the accepting edge plus n0 further edges; leaves once in DONE.
    task automatic wait_done(input string name, input int n0, output logic [127:0] exp_blk);
        int n = n0;
        exp_blk = 'x;
        if (exp_q.size() > 0) exp_blk = exp_q.pop_front();
        while (out_valid !== 1'b1 && n < 30) begin
            n_checks++;
            if (dp_round_key !== mdl_key[128*(n+1) +: 128] || dp_last !== (n == 9)) begin
                n_fail++;
                $display("FAIL %s round %0d: key=%h last=%b, required key=%h last=%b", name, n + 1,
                         dp_round_key, dp_last, mdl_key[128*(n+1) +: 128], (n == 9));
            end
            tick();
            n++;
        end
        n_checks++;
        if (n != 10) begin
            n_fail++;
            $display("FAIL %s latency: out_valid after %0d edges, required 10", name, n);
        end
        n_checks++;
        if (out_block !== exp_blk) begin
            n_fail++;
            $display("FAIL %s out_block: got %h, required %h", name, out_block, exp_blk);
        end
        n_checks++;
        if (dp_round_key !== 128'h0 || dp_last !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL %s done_outputs: key=%h last=%b busy=%b, required 0/0/1", name,
                     dp_round_key, dp_last, busy);
        end
    endtask

    task automatic drain(input string name);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s handshake: out_valid=%b busy=%b, required 0/0", name, out_valid, busy);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; key_load = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        expanded_key = '0; in_block = '0;
        #2 reset = 1'b0;
        #2;
        n_checks++;
        if ({in_ready, out_valid, busy, dp_last} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_ctrl: in_ready/out_valid/busy/dp_last=%b, required 0000",
                     {in_ready, out_valid, busy, dp_last});
        end
        n_checks++;
        if (dp_round_key !== 128'h0 || dp_state !== 128'h0 || out_block !== 128'h0) begin
            n_fail++;
            $display("FAIL reset_data: key=%h state=%h out=%h, required 0", dp_round_key,
                     dp_state, out_block);
        end
        @(posedge clk);
        #1 reset = 1'b1;
    endtask

    task automatic test_no_key();
        in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            in_block = rand128();
            #1;
            n_checks++;
            if (in_ready !== 1'b0 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL no_key cycle %0d: in_ready=%b busy=%b, required 0/0", i, in_ready, busy);
            end
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic test_fips();
        logic [1407:0] ek;
        logic [127:0]  e;
        ek = key_expand(128'h000102030405060708090a0b0c0d0e0f);
        n_checks++;
        if (ek[1407:1280] !== 128'h13111d7fe3944a17f307a78b4d2b30c5) begin
            n_fail++;
            $display("FAIL fips_keysched: rk10=%h, required 13111d7fe3944a17f307a78b4d2b30c5",
                     ek[1407:1280]);
        end
        load_key(ek);
        send_block("fips", 128'h00112233445566778899aabbccddeeff);
        wait_done("fips", 0, e);
        n_checks++;
        if (out_block !== 128'h69c4e0d86a7b0430d8cdb78070b4c55a) begin
            n_fail++;
            $display("FAIL fips_vector: got %h, required 69c4e0d86a7b0430d8cdb78070b4c55a", out_block);
        end
        drain("fips");
    endtask

    task automatic test_back_to_back();
        logic [127:0] e;
        for (int i = 0; i < 4; i++) begin
            if (i % 2 == 0) load_key(key_expand(rand128()));
            send_block("b2b", rand128());
            wait_done("b2b", 0, e);
            drain("b2b");
        end
    endtask

    task automatic test_backpressure();
        logic [127:0] e;
        send_block("bp", rand128());
        wait_done("bp", 0, e);
        for (int i = 0; i < 5; i++) begin
            in_valid  = 1'b1;
            in_block  = rand128();
            out_ready = 1'b0;
            #1;
            n_checks++;
            if (out_valid !== 1'b1 || out_block !== e || in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_stall cycle %0d: out_valid=%b in_ready=%b out=%h, required 1/0/%h",
                         i, out_valid, in_ready, out_block, e);
            end
            tick();
        end
        in_valid = 1'b0;
        drain("bp");
    endtask

    task automatic test_key_collision();
        logic [1407:0] nk;
        logic [127:0]  b;
        logic [127:0]  e;
        nk = key_expand(rand128());
        b  = rand128();
        in_valid = 1'b1; in_block = b;
        key_load = 1'b1; expanded_key = nk;
        #1;
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL collision_ready: in_ready=%b during key_load, required 0", in_ready);
        end
        tick();
        key_load = 1'b0;
        mdl_key  = nk;
        #1;
        n_checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL collision_next: in_ready=%b busy=%b, required 1/0", in_ready, busy);
        end
        tick();
        in_valid = 1'b0;
        exp_q.push_back(aes_encrypt(b, nk));
        wait_done("collision", 0, e);
        drain("collision");
    endtask

    task automatic test_key_during_round();
        logic [127:0] e;
        send_block("key_in_round", rand128());
        repeat (4) tick();
        key_load     = 1'b1;
        expanded_key = key_expand(rand128());
        tick();
        key_load = 1'b0;
        wait_done("key_in_round", 5, e);
        drain("key_in_round");
        send_block("key_kept", rand128());
        wait_done("key_kept", 0, e);
        drain("key_kept");
    endtask

    task automatic test_reset_mid();
        logic [1407:0] k;
        logic [127:0]  e;
        k = key_expand(rand128());
        load_key(k);
        send_block("rst_mid", rand128());
        repeat (5) tick();
        reset = 1'b0;
        #1;
        n_checks++;
        if ({in_ready, out_valid, busy, dp_last} !== 4'b0000) begin
            n_fail++;
            $display("FAIL rst_mid_ctrl: in_ready/out_valid/busy/dp_last=%b, required 0000",
                     {in_ready, out_valid, busy, dp_last});
        end
        n_checks++;
        if (dp_round_key !== 128'h0 || dp_state !== 128'h0 || out_block !== 128'h0) begin
            n_fail++;
            $display("FAIL rst_mid_data: key=%h state=%h out=%h, required 0", dp_round_key,
                     dp_state, out_block);
        end
        exp_q.delete();
        tick();
        tick();
        reset = 1'b1;
        in_valid = 1'b1;
        for (int i = 0; i < 15; i++) begin
            in_block = rand128();
            #1;
            n_checks++;
            if (in_ready !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL rst_mid_after cycle %0d: in_ready=%b busy=%b out_valid=%b, required 0",
                         i, in_ready, busy, out_valid);
            end
            tick();
        end
        key_load = 1'b1;
        expanded_key = k;
        tick();
        key_load = 1'b0;
        mdl_key  = k;
        send_block("rst_mid_new", rand128());
        wait_done("rst_mid_new", 0, e);
        drain("rst_mid_new");
    endtask

    initial begin
        test_reset();
        test_no_key();
        test_fips();
        test_back_to_back();
        test_backpressure();
        test_key_collision();
        test_key_during_round();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: bench did not complete in time");
        $fatal(1);
    end

endmodule

// File: doc/aes_round_controller.md
AES_ROUND_CONTROLLER -- requirements
Module: aes_round_controller

Interface
REQ-001 SHALL have no parameters; all widths are fixed for AES-128 with 10 rounds.
REQ-002 SHALL have ports `clk`, `reset`, `key_load`, `expanded_key`, `in_valid`, `in_ready` and `in_block`:
- `clk` input 1: the single clock; all state changes on its rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `key_load` input 1: a pulse that latches `expanded_key`.
- `expanded_key` input 1408: round key r (r = 0..10) occupies bits [128r+127:128r].
- `in_valid` input 1: plaintext block offered.
- `in_ready` output 1: controller accepts a block this cycle.
- `in_block` input 128: plaintext block.
REQ-003 SHALL have ports `dp_state`, `dp_round_key`, `dp_last`, `dp_result`, `out_valid`, `out_ready`, `out_block` and `busy`:
- `dp_state` output 128: current state sent to the external round datapath.
- `dp_round_key` output 128: round key for the current round.
- `dp_last` output 1: final round, so the datapath omits MixColumns.
- `dp_result` input 128: combinational round result from the datapath.
- `out_valid` output 1: ciphertext is available.
- `out_ready` input 1: the consumer accepts the ciphertext.
- `out_block` output 128: ciphertext.
- `busy` output 1: high whenever the state is not IDLE.

Function
REQ-004 SHALL register `expanded_key` into an internal 1408-bit key register on a rising edge with `key_load`=1 while the state is IDLE or DONE, and set a `key_valid` flag.
REQ-005 SHALL ignore `key_load` in state ROUND, leaving both the key register and `key_valid` unchanged.
REQ-006 SHALL implement the state machine IDLE -> ROUND -> DONE -> IDLE.
REQ-007 SHALL drive `in_ready` = (state==IDLE) & `key_valid` & ~`key_load`; a key load in the same cycle wins and no block is accepted.
REQ-008 SHALL, on an accepting edge (`in_valid` & `in_ready`), load the state register with `in_block` XOR round key 0, set the round counter to 1, and enter ROUND.
REQ-009 SHALL use a 4-bit round counter, holding 1..10 in ROUND and 0 otherwise.
REQ-010 SHALL, in ROUND, drive:
- `dp_state` = the state register;
- `dp_round_key` = the key register slice for the current round count;
- `dp_last` = (round count == 10).
REQ-011 SHALL, on each ROUND edge, load the state register from `dp_result` and increment the round counter; on the edge with round count 10 it enters DONE with the counter cleared.
REQ-012 SHALL drive `dp_round_key` and `dp_last` to 0 outside ROUND; `dp_state` always shows the state register.
REQ-013 SHALL assert `out_valid` exactly while in DONE, with `out_block` = the state register, held stable until the handshake.
REQ-014 SHALL return to IDLE on the edge where `out_valid` & `out_ready`; a DONE/IDLE overlap never occurs, so the minimum spacing is 12 cycles per block.
REQ-015 SHALL assert `out_valid` exactly 10 rising edges after the accepting edge when no reset intervenes.
REQ-016 SHALL keep `in_ready` at 0 during ROUND and DONE; `in_valid` in those states has no effect.
REQ-017 SHALL leave `in_ready` at 0 while `key_valid`=0; blocks are never accepted before a key is loaded.

Reset
REQ-018 SHALL, while `reset`=0 (asynchronous, with no clock required), force:
- state IDLE;
- round counter 0;
- `key_valid` 0;
- the state register and key register to all zeros.
REQ-019 SHALL therefore show these output values during reset: `in_ready`=0, `out_valid`=0, `busy`=0, `dp_last`=0, `dp_round_key`=0, `dp_state`=0, `out_block`=0.
REQ-020 SHALL, on reset mid-ROUND or mid-DONE, discard the block in flight; no `out_valid` is produced for it.
REQ-021 SHALL, after reset is released, require a new key load before any block is accepted.

Verification
REQ-022 SHALL cover the FIPS-197 vector:
- stimulus: key 000102..0f expanded with a reference model; `in_block` 00112233445566778899aabbccddeeff; the bench supplies a behavioral round datapath;
- required response: `out_block` 69c4e0d86a7b0430d8cdb78070b4c55a, with `out_valid` rising 10 edges after acceptance.
REQ-023 SHALL cover back-pressure: hold `out_ready`=0 for 5 cycles in DONE -> `out_valid` and `out_block` stay stable and `in_ready` stays 0; assert `out_ready` -> IDLE on the next edge.
REQ-024 SHALL cover the simultaneous event: `key_load`=1 and `in_valid`=1 in IDLE with `key_valid`=1 -> the key is updated, no block is accepted that cycle, and the block is accepted on the following cycle using the new key.
REQ-025 SHALL cover a key load during ROUND: pulse `key_load` with different key bits at round 5 -> the ciphertext still matches the original key, and the key register is unchanged.
REQ-026 SHALL cover reset mid-operation: drive `reset` low during round 6 -> all outputs are 0 immediately, no `out_valid` appears after release, and `in_valid` is ignored until `key_load`.
REQ-027 SHALL cover the no-key case after reset: `in_valid`=1 for 20 cycles with no key load -> `in_ready` stays 0 and `busy` stays 0.
